// File: rtl/life_sequencer.sv
// life_sequencer: generation scheduler for the 32x32 Game of Life grid.
// Paces grid updates to frame_start pulses (one generation every speed+1
// frames), provides run/pause/single-step/reload control and counts
// generations since the last seed load.
// Optional feature: define LIFE_STALL_DETECT_EN to auto-pause when the
// pattern becomes a still life or dies out (sticky 'stalled' flag).
module life_sequencer #(
  parameter int GRID_BITS = 1024,
  parameter int GEN_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic                 reload,
  input  logic [2:0]           speed,
  input  logic                 frame_start,
  input  logic [GRID_BITS-1:0] grid_pack,
  output logic                 gen_en,
  output logic                 grid_load,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 running,
  output logic                 stalled
);

  // S_INIT exists only so grid_load can pulse on the first cycle after reset
  // while every output stays 0 during reset itself.
  typedef enum logic [2:0] {
    S_INIT,
    S_LOAD,
    S_PAUSED,
    S_RUN,
    S_STEP_WAIT,
    S_FIRE,
    S_CHECK
  } state_t;

  state_t     state, state_n;
  logic [2:0] fcnt, fcnt_n;
  logic       from_run, from_run_n;
  logic       rl_pend;
  logic       reload_eff;
  logic       stall_hit;
  logic       stall_q;

`ifdef LIFE_STALL_DETECT_EN
  logic [GRID_BITS-1:0] snap;

  // Capture the old generation while the grid is being updated.
  always_ff @(posedge clk) begin
    if (state == S_FIRE) snap <= grid_pack;
  end

  // In CHECK the grid holds the new generation: unchanged or empty means stall.
  always_comb begin
    stall_hit = (state == S_CHECK) && ((grid_pack == snap) || (grid_pack == '0));
  end

  // Sticky stall flag, cleared only by a seed load or reset.
  always_ff @(posedge clk) begin
    if (reset)                  stall_q <= 1'b0;
    else if (state_n == S_LOAD) stall_q <= 1'b0;
    else if (stall_hit)         stall_q <= 1'b1;
  end

  // Drive the stall output from the sticky register.
  always_comb stalled = stall_q;
`else
  logic grid_unused;
  assign grid_unused = ^grid_pack;

  // Stall detection compiled out: never stalls.
  always_comb begin
    stall_hit = 1'b0;
    stall_q   = 1'b0;
    stalled   = 1'b0;
  end
`endif

  // A reload held off during FIRE/CHECK is serviced like a fresh pulse.
  always_comb reload_eff = reload | rl_pend;

  // Next-state logic; priority reload > run=0 > step > frame_start.
  always_comb begin
    state_n    = state;
    fcnt_n     = fcnt;
    from_run_n = from_run;
    case (state)
      S_INIT: state_n = S_LOAD;
      S_LOAD: state_n = S_PAUSED;
      S_PAUSED: begin
        if (reload_eff)            state_n = S_LOAD;
        else if (step)             state_n = S_STEP_WAIT;
        else if (run && !stall_q) begin
          state_n = S_RUN;
          fcnt_n  = speed;
        end
      end
      S_RUN: begin
        if (reload_eff)        state_n = S_LOAD;
        else if (!run)         state_n = S_PAUSED;
        else if (frame_start) begin
          if (fcnt == 3'd0) begin
            state_n    = S_FIRE;
            fcnt_n     = speed;
            from_run_n = 1'b1;
          end else begin
            fcnt_n = fcnt - 3'd1;
          end
        end
      end
      S_STEP_WAIT: begin
        if (reload_eff)       state_n = S_LOAD;
        else if (frame_start) begin
          state_n    = S_FIRE;
          from_run_n = 1'b0;
        end
      end
      S_FIRE:  state_n = S_CHECK;
      S_CHECK: state_n = (from_run && run && !stall_hit && !stall_q) ? S_RUN : S_PAUSED;
      default: state_n = S_LOAD;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_INIT;
      fcnt      <= '0;
      from_run  <= 1'b0;
      rl_pend   <= 1'b0;
      gen_en    <= 1'b0;
      grid_load <= 1'b0;
      running   <= 1'b0;
      gen_count <= '0;
    end else begin
      state     <= state_n;
      fcnt      <= fcnt_n;
      from_run  <= from_run_n;
      gen_en    <= (state_n == S_FIRE);
      grid_load <= (state_n == S_LOAD);
      running   <= (state_n == S_RUN);
      if (state_n == S_LOAD) begin
        gen_count <= '0;
        rl_pend   <= 1'b0;
      end else begin
        if (state == S_FIRE) gen_count <= gen_count + GEN_W'(1);
        if (((state == S_FIRE) || (state == S_CHECK)) && reload) rl_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_life_sequencer.sv
// Testbench for life_sequencer: directed scenarios followed by a randomized
// run, every cycle compared against a behavioural model of the sequencer.
// Honours LIFE_STALL_DETECT_EN in its expectations.
module tb_life_sequencer;
  localparam int GB = 1024;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          reset, run, step, reload, frame_start;
  logic [2:0]    speed;
  logic [GB-1:0] grid_pack;
  logic          gen_en, grid_load, running, stalled;
  logic [GW-1:0] gen_count;

  always #5 clk = ~clk;

  life_sequencer #(.GRID_BITS(GB), .GEN_W(GW)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .reload(reload),
    .speed(speed), .frame_start(frame_start), .grid_pack(grid_pack),
    .gen_en(gen_en), .grid_load(grid_load), .gen_count(gen_count),
    .running(running), .stalled(stalled)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase of the scheduler, frames counted up since the
  // last fire/entry, and the frame period latched at entry/fire.
  typedef enum int {P_RESET, P_LOAD, P_PAUSE, P_RUN, P_STEP, P_FIRE, P_CHECK} ph_t;
  ph_t           ph = P_RESET;
  int            seen = 0;
  int            period = 0;
  bit            came_from_run = 0;
  bit            m_pend = 0;
  bit            m_stalled = 0;
  int unsigned   m_gen = 0;
  logic [GB-1:0] m_old = '0;

  int fs_period = 0;
  int fs_cnt = 0;
  bit fs_random = 0;
  int en_seen = 0;
  int m_en = 0;

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enter_load();
    ph        = P_LOAD;
    m_gen     = 0;
    m_stalled = 0;
    m_pend    = 0;
  endtask

  task automatic model_edge();
    bit rl;
    if (reset) begin
      ph = P_RESET; m_gen = 0; m_stalled = 0; m_pend = 0; seen = 0; period = 0;
      return;
    end
    rl = reload || m_pend;
    case (ph)
      P_RESET: enter_load();
      P_LOAD:  ph = P_PAUSE;
      P_PAUSE: begin
        if (rl) enter_load();
        else if (step) ph = P_STEP;
        else if (run && !m_stalled) begin
          ph = P_RUN; seen = 0; period = int'(speed);
        end
      end
      P_RUN: begin
        if (rl) enter_load();
        else if (!run) ph = P_PAUSE;
        else if (frame_start) begin
          seen++;
          if (seen > period) begin
            ph = P_FIRE; came_from_run = 1; seen = 0; period = int'(speed);
          end
        end
      end
      P_STEP: begin
        if (rl) enter_load();
        else if (frame_start) begin
          ph = P_FIRE; came_from_run = 0;
        end
      end
      P_FIRE: begin
        m_gen = (m_gen + 1) % 65536;
        m_old = grid_pack;
        if (reload) m_pend = 1;
        ph = P_CHECK;
      end
      P_CHECK: begin
        if (reload) m_pend = 1;
`ifdef LIFE_STALL_DETECT_EN
        if ((grid_pack == m_old) || (grid_pack == '0)) m_stalled = 1;
`endif
        ph = (came_from_run && run && !m_stalled) ? P_RUN : P_PAUSE;
      end
      default: ph = P_RESET;
    endcase
  endtask

  task automatic compare();
    chk1("gen_en",    32'(gen_en),    32'(ph == P_FIRE));
    chk1("grid_load", 32'(grid_load), 32'(ph == P_LOAD));
    chk1("running",   32'(running),   32'(ph == P_RUN));
    chk1("gen_count", 32'(gen_count), m_gen);
    chk1("stalled",   32'(stalled),   32'(m_stalled));
    if (gen_en === 1'b1) en_seen++;
    if (ph == P_FIRE) m_en++;
  endtask

  task automatic tick();
    if (fs_period != 0) begin
      fs_cnt++;
      if (fs_cnt >= fs_period) begin
        frame_start = 1'b1;
        fs_cnt = 0;
        if (fs_random) fs_period = $urandom_range(3, 8);
      end
    end
    @(posedge clk);
    model_edge();
    #1;
    compare();
    step = 1'b0;
    reload = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic rand_grid();
    for (int i = 0; i < GB / 32; i++) grid_pack[i*32 +: 32] = $urandom();
  endtask

  initial begin
    int base;
    int r;
    reset = 1'b1; run = 1'b0; step = 1'b0; reload = 1'b0;
    frame_start = 1'b0; speed = 3'd0; grid_pack = '0;

    // Reset, then release: one-cycle grid_load, then paused.
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk1("load_pulse", 32'(grid_load), 32'd1);
    tick();
    chk1("load_end", 32'(grid_load), 32'd0);
    chk1("paused_not_running", 32'(running), 32'd0);

    // Free run at speed 2 with a frame every 100 cycles: fires on frames 3, 6, 9.
    run = 1'b1; speed = 3'd2; fs_period = 100; fs_cnt = 0;
    base = en_seen;
    for (int i = 0; i < 950; i++) begin
      rand_grid();
      tick();
    end
    chk1("run_pulses", 32'(en_seen - base), 32'd3);
    chk1("run_gen", 32'(gen_count), 32'd3);
    chk1("run_running", 32'(running), 32'd1);

    // Pause, single step (extra step pulse ignored), two frames: one generation.
    run = 1'b0;
    tick();
    base = en_seen;
    step = 1'b1; tick();
    step = 1'b1; tick();
    for (int i = 0; i < 250; i++) begin
      rand_grid();
      tick();
    end
    chk1("step_pulses", 32'(en_seen - base), 32'd1);
    chk1("step_gen", 32'(gen_count), 32'd4);

    // Reach gen 5, then reload coincident with a firing frame: LOAD wins.
    fs_period = 0;
    run = 1'b1; speed = 3'd0;
    rand_grid();
    repeat (3) tick();
    frame_start = 1'b1; tick();
    rand_grid();
    repeat (4) tick();
    chk1("gen_five", 32'(gen_count), 32'd5);
    frame_start = 1'b1; reload = 1'b1; tick();
    chk1("reload_no_en", 32'(gen_en), 32'd0);
    chk1("reload_load", 32'(grid_load), 32'd1);
    chk1("reload_gen0", 32'(gen_count), 32'd0);
    run = 1'b0;
    tick();
    chk1("reload_paused", 32'(running), 32'd0);

    // Reload during FIRE is held pending and serviced after CHECK.
    run = 1'b1;
    repeat (2) tick();
    frame_start = 1'b1; tick();
    reload = 1'b1; rand_grid(); tick();
    tick();
    tick();
    chk1("pend_load", 32'(grid_load), 32'd1);
    run = 1'b0;
    tick();

    // Still-life block on the grid with run=1, speed 1, frame every 20 cycles.
    grid_pack = '0;
    grid_pack[10*32+10] = 1'b1; grid_pack[10*32+11] = 1'b1;
    grid_pack[11*32+10] = 1'b1; grid_pack[11*32+11] = 1'b1;
    run = 1'b1; speed = 3'd1; fs_period = 20; fs_cnt = 0;
    base = en_seen;
    repeat (410) tick();
`ifdef LIFE_STALL_DETECT_EN
    chk1("stall_set", 32'(stalled), 32'd1);
    chk1("stall_pulses", 32'(en_seen - base), 32'd1);
`else
    chk1("stall_none", 32'(stalled), 32'd0);
    chk1("stall_pulses", 32'(en_seen - base), 32'd10);
`endif
    fs_period = 0;
    reload = 1'b1; tick();
    chk1("stall_cleared", 32'(stalled), 32'd0);
    run = 1'b0;
    tick();

    // Randomized phase with random frame spacing (always >= 3 cycles).
    fs_random = 1'b1; fs_period = 5; fs_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) run = ~run;
      step   = ($urandom_range(0, 9) == 0);
      reload = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 49) == 0) speed = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 15);
      if (r == 0) grid_pack = '0;
      else if (r > 5) rand_grid();
      tick();
    end
    reset = 1'b0;
    chk1("model_pulse_total", 32'(en_seen), 32'(m_en));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
